sync_fifo_dpmem: RTL and testbench
==================================

SYNC_FIFO_DPMEM -- requirements
Module: sync_fifo_dpmem

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADD_WIDTH, default 4, address width; depth = 2**ADD_WIDTH.
REQ-003 SHALL have parameter IDELOUTPUT, default all-zero WIDTH bits, Dataout value when no read is accepted.
REQ-004 SHALL have parameter AF_LEVEL, default 2**ADD_WIDTH-2, AlmostFull threshold in words.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: Clk input 1 is the single clock, rising edge; Rst input 1 is the asynchronous active-high reset.
REQ-006 SHALL have the remaining ports:
- Wen input 1: write request.
- Datain input WIDTH: write data.
- Ren input 1: read request.
- Dataout output WIDTH: registered read data.
- Rvalid output 1: Dataout holds a popped word.
- Full output 1: FIFO full.
- Empty output 1: FIFO empty.
- AlmostFull output 1: Count >= AF_LEVEL.
- Count output ADD_WIDTH+1: words stored.
- ClrErr input 1: clears the sticky error flags.
- Overflow output 1: sticky, write refused.
- Underflow output 1: sticky, read refused.

Function
REQ-007 SHALL accept a write when Wen=1 and Full=0: Datain is stored at wptr and wptr increments mod depth.
REQ-008 SHALL refuse a write when Wen=1 and Full=1, even if a read is accepted in the same cycle; no state changes.
REQ-009 SHALL accept a read when Ren=1 and Empty=0: next edge Dataout=mem[rptr], Rvalid=1, and rptr increments mod depth; latency is 1 cycle.
REQ-010 SHALL, in any cycle without an accepted read, load Dataout with IDELOUTPUT and Rvalid with 0 at the next edge.
REQ-011 SHALL, on Wen=1 and Ren=1 when Empty=1, accept the write only; there is no fall-through and Dataout=IDELOUTPUT.
REQ-012 SHALL, on simultaneous accepted read and write, leave Count unchanged and advance both pointers.
REQ-013 SHALL update Count by +1 on a write only, -1 on a read only, and 0 otherwise; Count ranges 0..2**ADD_WIDTH.
REQ-014 SHALL drive Full, Empty and AlmostFull combinationally from registered Count: Full = (Count == depth), Empty = (Count == 0).
REQ-015 SHALL wrap pointers from depth-1 to 0 with no gap; the word order read SHALL equal the word order written.

Reset
REQ-016 SHALL, while Rst=1, asynchronously clear wptr, rptr and Count to 0, Dataout to IDELOUTPUT, Rvalid to 0, and Overflow and Underflow to 0.
REQ-017 SHALL leave memory contents uncleared on reset; words in flight are discarded and Empty=1 from reset assertion.
REQ-018 SHALL accept the first write at the first rising Clk edge after Rst deasserts.

Configuration
REQ-019 SHALL, with macro SYNC_FIFO_DPMEM_ERR_FLAGS_EN defined, set Overflow on a refused write and Underflow on a refused read; each flag holds until ClrErr=1 at a clock edge. A set and ClrErr in the same cycle SHALL leave the flag set.
REQ-020 SHALL, without SYNC_FIFO_DPMEM_ERR_FLAGS_EN, tie Overflow and Underflow to 0, ignore ClrErr, and add no flag registers.

Structure
REQ-021 SHALL place shared constants in package sync_fifo_dpmem_pkg: default WIDTH/ADD_WIDTH and a function returning the Count width (ADD_WIDTH+1).
REQ-022 SHALL instantiate one sub-module, dpmem_param: a parametrised WIDTH x 2**ADD_WIDTH single-clock memory with a registered write port and an asynchronous read port. The FIFO control SHALL hold pointers, Count, flags and the Dataout register.

Verification (WIDTH=8, ADD_WIDTH=4, AF_LEVEL=14, IDELOUTPUT=8'h00, macro defined)
REQ-023 Fill/drain: write 8'h01..8'h10 (16 words) -> Full=1 and Count=16 after the 16th edge; 16 reads -> Dataout 8'h01..8'h10 in order, each 1 cycle after Ren, then Empty=1.
REQ-024 Overflow: with Full=1, Wen=1 Datain=8'hAA -> Count stays 16 and Overflow=1 next edge; a later read returns 8'h01, not 8'hAA; ClrErr=1 -> Overflow=0.
REQ-025 Underflow/idle: with Empty=1, Ren=1 -> Dataout=8'h00, Rvalid=0, Underflow=1; with Empty=1, Wen=Ren=1 Datain=8'h55 -> Count=1, Dataout=8'h00.
REQ-026 Wrap and concurrency: at Count=8, 40 cycles of simultaneous Wen/Ren with an incrementing pattern -> Count stays 8, output sequence is gap-free and in order, and pointers wrap at 15->0.
REQ-027 Thresholds: 14 writes -> AlmostFull rises on the 14th edge; one read -> AlmostFull falls.
REQ-028 Reset mid-operation: Rst pulse while Count=5 and a read is pending -> Count=0, Empty=1, Dataout=8'h00 and Rvalid=0 immediately, without waiting for a Clk edge.

Source files
------------

// File: rtl/sync_fifo_dpmem_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_dpmem_pkg
// Shared constants for the synchronous FIFO built on a dual-port memory:
//   DEF_WIDTH      default data word width in bits
//   DEF_ADD_WIDTH  default address width (depth = 2**ADD_WIDTH)
//   count_width()  width of the occupancy counter, which must hold 0..depth
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package sync_fifo_dpmem_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ADD_WIDTH = 4;

  // One extra bit so the counter can represent a completely full FIFO.
  function automatic int count_width(input int add_width);
    return add_width + 1;
  endfunction

endpackage

// File: rtl/dpmem_param.sv
// -----------------------------------------------------------------------------
// dpmem_param
// WIDTH x 2**ADD_WIDTH single-clock memory: registered write port, asynchronous
// read port. Contents are not reset.
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dpmem_param #(
  parameter int WIDTH     = 8,
  parameter int ADD_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADD_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic [ADD_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADD_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_dpmem.sv
// -----------------------------------------------------------------------------
// sync_fifo_dpmem
// Synchronous FIFO on a dual-port memory with a registered, 1-cycle-latency
// read output. Optional sticky error flags are built when the macro
// SYNC_FIFO_DPMEM_ERR_FLAGS_EN is defined; otherwise Overflow/Underflow are 0
// and ClrErr is ignored.
// Ports:
//   Clk         clock, rising edge
//   Rst         asynchronous active-high reset
//   Wen/Datain  write request and data (accepted when not Full)
//   Ren         read request (accepted when not Empty)
//   Dataout     registered read data, IDELOUTPUT when no read was accepted
//   Rvalid      Dataout holds a popped word
//   Full/Empty  occupancy status from the registered count
//   AlmostFull  Count >= AF_LEVEL
//   Count       words stored, 0..2**ADD_WIDTH
//   ClrErr      clears the sticky error flags
//   Overflow    sticky: a write was refused
//   Underflow   sticky: a read was refused
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_fifo_dpmem
  import sync_fifo_dpmem_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter logic [WIDTH-1:0] IDELOUTPUT = '0,
  parameter int               AF_LEVEL   = 2**ADD_WIDTH - 2
) (
  input  logic                                Clk,
  input  logic                                Rst,
  input  logic                                Wen,
  input  logic [WIDTH-1:0]                    Datain,
  input  logic                                Ren,
  output logic [WIDTH-1:0]                    Dataout,
  output logic                                Rvalid,
  output logic                                Full,
  output logic                                Empty,
  output logic                                AlmostFull,
  output logic [count_width(ADD_WIDTH)-1:0]   Count,
  input  logic                                ClrErr,
  output logic                                Overflow,
  output logic                                Underflow
);

  localparam int            CW     = count_width(ADD_WIDTH);
  localparam logic [CW-1:0] DEPTH  = CW'(2**ADD_WIDTH);
  localparam logic [CW-1:0] AF_LVL = CW'(AF_LEVEL);

  logic [ADD_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADD_WIDTH-1:0] rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 rvalid_q, rvalid_d;
  logic [WIDTH-1:0]     mem_rdata;
  logic                 wr_ok, rd_ok;

  assign Full       = (count_q == DEPTH);
  assign Empty      = (count_q == '0);
  assign AlmostFull = (count_q >= AF_LVL);

  // A write is refused when full even if a read frees a slot this cycle; a
  // read on an empty FIFO never falls through to the word being written.
  assign wr_ok = Wen & ~Full;
  assign rd_ok = Ren & ~Empty;

  dpmem_param #(
    .WIDTH     (WIDTH),
    .ADD_WIDTH (ADD_WIDTH)
  ) u_mem (
    .clk_i   (Clk),
    .we_i    (wr_ok),
    .waddr_i (wptr_q),
    .wdata_i (Datain),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    dout_d   = IDELOUTPUT;
    rvalid_d = 1'b0;
    // Pointers are exactly ADD_WIDTH bits wide, so they wrap depth-1 -> 0.
    if (wr_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d   = rptr_q + 1'b1;
      dout_d   = mem_rdata;
      rvalid_d = 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dout_q   <= IDELOUTPUT;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign Dataout = dout_q;
  assign Rvalid  = rvalid_q;
  assign Count   = count_q;

`ifdef SYNC_FIFO_DPMEM_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Clear first, then set: a refusal coincident with ClrErr keeps the flag.
  always_comb begin
    ovf_d = ClrErr ? 1'b0 : ovf_q;
    unf_d = ClrErr ? 1'b0 : unf_q;
    if (Wen && Full) begin
      ovf_d = 1'b1;
    end
    if (Ren && Empty) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
`else
  logic unused_clrerr;
  assign unused_clrerr = ClrErr;
  assign Overflow      = 1'b0;
  assign Underflow     = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_dpmem.sv
`timescale 1ns/1ps
module tb_sync_fifo_dpmem;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Wen = 1'b0;
  logic [7:0] Datain = 8'h00;
  logic       Ren = 1'b0;
  logic [7:0] Dataout;
  logic       Rvalid, Full, Empty, AlmostFull;
  logic [4:0] Count;
  logic       ClrErr = 1'b0;
  logic       Overflow, Underflow;

  int total = 0;
  int bad   = 0;

`ifdef SYNC_FIFO_DPMEM_ERR_FLAGS_EN
  localparam logic FLG = 1'b1;
`else
  localparam logic FLG = 1'b0;
`endif

  sync_fifo_dpmem #(
    .WIDTH      (8),
    .ADD_WIDTH  (4),
    .IDELOUTPUT (8'h00),
    .AF_LEVEL   (14)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Wen        (Wen),
    .Datain     (Datain),
    .Ren        (Ren),
    .Dataout    (Dataout),
    .Rvalid     (Rvalid),
    .Full       (Full),
    .Empty      (Empty),
    .AlmostFull (AlmostFull),
    .Count      (Count),
    .ClrErr     (ClrErr),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_count", Count, 0);
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_dout", Dataout, 8'h00);
    check("rst_rvalid", Rvalid, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_unf", Underflow, 0);
    tick();
    Rst = 1'b0;

    // Fill 0x01..0x10; AlmostFull rises on the 14th write edge
    for (int i = 1; i <= 16; i++) begin
      Wen = 1'b1; Datain = 8'(i);
      tick();
      check("fill_count", Count, i);
      if (i == 13) check("af_13", AlmostFull, 0);
      if (i == 14) check("af_14", AlmostFull, 1);
    end
    Wen = 1'b0;
    check("fill_full", Full, 1);
    check("fill_count16", Count, 16);
    check("fill_dout_idle", Dataout, 8'h00);

    // Overflow: write while full is refused
    Wen = 1'b1; Datain = 8'hAA;
    tick();
    Wen = 1'b0;
    check("ovf_count", Count, 16);
    check("ovf_flag", Overflow, FLG);
    tick();
    check("ovf_sticky", Overflow, FLG);
    ClrErr = 1'b1;
    tick();
    ClrErr = 1'b0;
    check("ovf_clr", Overflow, 0);

    // Drain: data in order, one cycle after Ren, AlmostFull falls at 13
    for (int i = 1; i <= 16; i++) begin
      Ren = 1'b1;
      tick();
      check("drain_data", Dataout, i);
      check("drain_rvalid", Rvalid, 1);
      check("drain_count", Count, 16 - i);
      if (i == 2) check("af_14_hold", AlmostFull, 1);
      if (i == 3) check("af_fall", AlmostFull, 0);
    end
    check("drain_empty", Empty, 1);
    Ren = 1'b0;
    tick();
    check("idle_dout", Dataout, 8'h00);
    check("idle_rvalid", Rvalid, 0);

    // Underflow on empty read, then set-while-clear keeps the flag
    Ren = 1'b1;
    tick();
    check("unf_dout", Dataout, 8'h00);
    check("unf_rvalid", Rvalid, 0);
    check("unf_flag", Underflow, FLG);
    ClrErr = 1'b1;
    tick();
    check("unf_set_wins", Underflow, FLG);
    Ren = 1'b0;
    tick();
    ClrErr = 1'b0;
    check("unf_clr", Underflow, 0);

    // Simultaneous write/read on empty: write only, no fall-through
    Wen = 1'b1; Ren = 1'b1; Datain = 8'h55;
    tick();
    Wen = 1'b0; Ren = 1'b0;
    check("wr_empty_count", Count, 1);
    check("wr_empty_dout", Dataout, 8'h00);
    check("wr_empty_rvalid", Rvalid, 0);
    Ren = 1'b1;
    tick();
    Ren = 1'b0;
    check("wr_empty_read", Dataout, 8'h55);
    check("wr_empty_cnt0", Count, 0);

    // Wrap and concurrency: 8 deep, 40 cycles of simultaneous traffic
    for (int i = 0; i < 8; i++) begin
      Wen = 1'b1; Datain = 8'(8'h80 + i);
      tick();
    end
    check("wrap_count8", Count, 8);
    for (int k = 0; k < 40; k++) begin
      Wen = 1'b1; Ren = 1'b1; Datain = 8'(8'h88 + k);
      tick();
      check("wrap_data", Dataout, 8'(8'h80 + k));
      check("wrap_rvalid", Rvalid, 1);
      check("wrap_count", Count, 8);
    end
    Wen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      Ren = 1'b1;
      tick();
      check("wrap_tail", Dataout, 8'(8'hA8 + k));
    end
    Ren = 1'b0;
    check("wrap_empty", Empty, 1);

    // Reset mid-operation with a read pending
    for (int i = 0; i < 6; i++) begin
      Wen = 1'b1; Datain = 8'(8'hC0 + i);
      tick();
    end
    Wen = 1'b0; Ren = 1'b1;
    tick();
    check("mid_pre_dout", Dataout, 8'hC0);
    check("mid_pre_count", Count, 5);
    #2;
    Rst = 1'b1;
    #1;
    check("mid_count", Count, 0);
    check("mid_empty", Empty, 1);
    check("mid_dout", Dataout, 8'h00);
    check("mid_rvalid", Rvalid, 0);
    Ren = 1'b0;
    #1;
    Rst = 1'b0;

    // First write after reset release is accepted
    Wen = 1'b1; Datain = 8'h77;
    tick();
    Wen = 1'b0;
    check("post_rst_count", Count, 1);
    Ren = 1'b1;
    tick();
    Ren = 1'b0;
    check("post_rst_data", Dataout, 8'h77);
    check("post_rst_empty", Empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
